// File: rtl/tinyalu_param_if.sv
// ---------------------------------------------------------------------------
// tinyalu_param_if
// Command/response bundle for the parametrised TinyALU core.
//
// Signals:
//   start   master -> slave  level command request, held until done is seen
//   op      master -> slave  3-bit opcode
//   A, B    master -> slave  DATA_W-bit unsigned operands
//   done    slave  -> master one-cycle pulse, result/err valid
//   busy    slave  -> master high while a multiply iterates
//   err     slave  -> master illegal-op flag, valid with done
//   result  slave  -> master 2*DATA_W-bit result, held until next completion
//
// Handshake: the master raises start with op/A/B stable and keeps it high
// until it sees done. The slave captures once per start assertion; after a
// completion it ignores start until start has been seen low at one posedge.
// ---------------------------------------------------------------------------
interface tinyalu_param_if #(
    parameter int DATA_W = 8
);
    logic                  start;
    logic [2:0]            op;
    logic [DATA_W-1:0]     A;
    logic [DATA_W-1:0]     B;
    logic                  done;
    logic                  busy;
    logic                  err;
    logic [2*DATA_W-1:0]   result;

    modport master (
        output start, op, A, B,
        input  done, busy, err, result
    );

    modport slave (
        input  start, op, A, B,
        output done, busy, err, result
    );
endinterface

// File: rtl/tinyalu_param.sv
// ---------------------------------------------------------------------------
// tinyalu_param
// Parametrised TinyALU: add/and/xor in one cycle, multiply by iterative
// LSB-first shift-add over DATA_W cycles, illegal opcodes flagged via err.
//
// Ports:
//   clk      clock, all state changes on posedge
//   reset_n  asynchronous active-low reset
//   bus      tinyalu_param_if slave modport (start/op/A/B in,
//            done/busy/err/result out)
//   state_o  debug view of the control FSM (0 IDLE, 1 MUL, 2 HOLD)
// ---------------------------------------------------------------------------
module tinyalu_param #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    tinyalu_param_if.slave        bus,
    output logic [1:0]            state_o
);

    localparam int MUL_ITER_W = $clog2(DATA_W + 1);
    localparam int RES_W      = 2 * DATA_W;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                 state_q;
    logic                   armed_q;
    logic                   done_q;
    logic                   busy_q;
    logic                   err_q;
    logic [RES_W-1:0]       result_q;
    logic [RES_W-1:0]       acc_q;
    logic [RES_W-1:0]       mcand_q;   // A, shifted left one place per step
    logic [DATA_W-1:0]      mplier_q;  // B, shifted right one place per step
    logic [MUL_ITER_W-1:0]  cnt_q;

    logic [RES_W-1:0]       acc_d;
    logic                   last_step;

    // One shift-add step: add the current multiplicand if the current
    // multiplier LSB is set. The accumulator is wide enough that it never
    // overflows.
    always_comb begin
        acc_d     = acc_q;
        last_step = (cnt_q == MUL_ITER_W'(DATA_W - 1));
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            armed_q  <= 1'b1;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            // done is a single-cycle pulse; every path that completes sets it
            // again explicitly.
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start && armed_q) begin
                        armed_q <= 1'b0;
                        state_q <= S_HOLD;
                        case (bus.op)
                            OP_NOP: begin
                                // no completion, result and err untouched
                            end
                            OP_ADD: begin
                                result_q <= RES_W'(bus.A) + RES_W'(bus.B);
                                err_q    <= 1'b0;
                                done_q   <= 1'b1;
                            end
                            OP_AND: begin
                                result_q <= RES_W'(bus.A & bus.B);
                                err_q    <= 1'b0;
                                done_q   <= 1'b1;
                            end
                            OP_XOR: begin
                                result_q <= RES_W'(bus.A ^ bus.B);
                                err_q    <= 1'b0;
                                done_q   <= 1'b1;
                            end
                            OP_MUL: begin
                                busy_q   <= 1'b1;
                                acc_q    <= '0;
                                cnt_q    <= '0;
                                mcand_q  <= RES_W'(bus.A);
                                mplier_q <= bus.B;
                                state_q  <= S_MUL;
                            end
                            default: begin
                                result_q <= '0;
                                err_q    <= 1'b1;
                                done_q   <= 1'b1;
                            end
                        endcase
                    end
                end

                S_MUL: begin
                    // Inputs are ignored here; operands were latched at capture.
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (last_step) begin
                        result_q <= acc_d;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        err_q    <= 1'b0;
                        state_q  <= S_HOLD;
                    end
                end

                S_HOLD: begin
                    // Re-arm only once start has been seen low, so a master
                    // holding start through done cannot issue twice.
                    if (!bus.start) begin
                        armed_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.done   = done_q;
    assign bus.busy   = busy_q;
    assign bus.err    = err_q;
    assign bus.result = result_q;
    assign state_o    = state_q;

endmodule
